// File: rtl/approx_cmp_err_monitor.sv
// Error monitor for the approximate comparator: registers each sample, compares the
// approximate EQ/GT/LT flags against the exact result, and reports per-window mismatch counts.
module approx_cmp_err_monitor #(
  parameter int W      = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_eq,
  input  logic             in_gt,
  input  logic             in_lt,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_samples,
  output logic [CNT_W-1:0] rpt_eq_err,
  output logic [CNT_W-1:0] rpt_gt_err,
  output logic [CNT_W-1:0] rpt_lt_err,
  output logic [CNT_W-1:0] rpt_any_err,
  output logic             rpt_overrun
);
  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  // flag vectors are ordered {eq, gt, lt}
  logic                  s1_valid_q;
  logic [2:0]            s1_exact_q, s1_approx_q;
  logic [CNT_W-1:0]      acc_samples_q, acc_any_q;
  logic [2:0][CNT_W-1:0] acc_err_q;

  logic [2:0]            mism;
  logic [CNT_W-1:0]      samp_inc, any_inc;
  logic [2:0][CNT_W-1:0] err_inc;
  logic                  close_win, load_rpt;

  logic                  rpt_valid_q, rpt_overrun_q;
  logic [CNT_W-1:0]      rpt_samples_q, rpt_any_q;
  logic [2:0][CNT_W-1:0] rpt_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else if (clr) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_exact_q  <= {in_a == in_b, in_a > in_b, in_a < in_b};
        s1_approx_q <= {in_eq, in_gt, in_lt};
      end
    end
  end

  always_comb begin
    mism      = s1_exact_q ^ s1_approx_q;
    samp_inc  = acc_samples_q + 1'b1;
    any_inc   = acc_any_q + CNT_W'(|mism);
    err_inc   = '0;
    for (int i = 0; i < 3; i++) err_inc[i] = acc_err_q[i] + CNT_W'(mism[i]);
    close_win = s1_valid_q && (samp_inc == WIN);
    load_rpt  = close_win && (!rpt_valid_q || rpt_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_samples_q <= '0;
      acc_any_q     <= '0;
      acc_err_q     <= '0;
    end else if (clr || close_win) begin
      acc_samples_q <= '0;
      acc_any_q     <= '0;
      acc_err_q     <= '0;
    end else if (s1_valid_q) begin
      acc_samples_q <= samp_inc;
      acc_any_q     <= any_inc;
      acc_err_q     <= err_inc;
    end
  end

  // A closing window that cannot be handed off is dropped and flagged; the held report wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_valid_q   <= 1'b0;
      rpt_overrun_q <= 1'b0;
      rpt_samples_q <= '0;
      rpt_any_q     <= '0;
      rpt_err_q     <= '0;
    end else if (clr) begin
      rpt_valid_q   <= 1'b0;
      rpt_overrun_q <= 1'b0;
      rpt_samples_q <= '0;
      rpt_any_q     <= '0;
      rpt_err_q     <= '0;
    end else if (load_rpt) begin
      rpt_valid_q   <= 1'b1;
      rpt_samples_q <= samp_inc;
      rpt_any_q     <= any_inc;
      rpt_err_q     <= err_inc;
    end else if (close_win) begin
      rpt_overrun_q <= 1'b1;
    end else if (rpt_valid_q && rpt_ready) begin
      rpt_valid_q   <= 1'b0;
    end
  end

  assign rpt_valid   = rpt_valid_q;
  assign rpt_overrun = rpt_overrun_q;
  assign rpt_samples = rpt_samples_q;
  assign rpt_eq_err  = rpt_err_q[2];
  assign rpt_gt_err  = rpt_err_q[1];
  assign rpt_lt_err  = rpt_err_q[0];
  assign rpt_any_err = rpt_any_q;

endmodule

// File: doc/approx_cmp_err_monitor.md
# approx_cmp_err_monitor

Downstream monitor for the 4-bit approximate comparator. Each cycle it takes the operands and the comparator's EQ/GT/LT flags, computes the exact unsigned comparison internally, and counts per-flag mismatches over a fixed window of samples. At the end of each window it emits a report over a valid/ready handshake. The block characterises approximation error in-system, next to the area-reduced comparator.

## Interface
- `W`, 4: operand width; must match the comparator.
- `CNT_W`, 16: width of every counter and report field.
- `WINDOW`, 256: samples per report.
  - Legal range: 1 ≤ `WINDOW` ≤ 2^`CNT_W`−1, so counters never wrap or saturate.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clr`  in  1: synchronous clear of all state; same effect as reset.
- `in_valid`  in  1: a sample is present this cycle.
- `in_a`, `in_b`  in  `W`: operands presented to the comparator.
- `in_eq`, `in_gt`, `in_lt`  in  1 each: approximate comparator outputs for `in_a`/`in_b`.
- `rpt_valid`  out  1: a report is pending.
- `rpt_ready`  in  1: the consumer accepts the report.
- `rpt_samples`  out  `CNT_W`: samples in the reported window; always equals `WINDOW`.
- `rpt_eq_err`, `rpt_gt_err`, `rpt_lt_err`  out  `CNT_W` each: mismatch count for each flag.
- `rpt_any_err`  out  `CNT_W`: samples where at least one flag mismatched.
- `rpt_overrun`  out  1: sticky; a completed window was dropped.

## Operation
**Stage 1 (capture).** When `in_valid`=1, the block registers:
- exact `eq` = (`in_a`==`in_b`), exact `gt` = (`in_a`>`in_b`), exact `lt` = (`in_a`<`in_b`), all unsigned;
- the three approximate flags;
- `s1_valid` = 1.

When `in_valid`=0, `s1_valid` = 0.

**Stage 2 (accumulate).** When `s1_valid`=1:
- `acc_samples` += 1;
- each `acc_x_err` += (approx_x != exact_x), for x in eq, gt, lt;
- `acc_any_err` += 1 if any of the three flags differs.

**Window close.** When the increment brings `acc_samples` to `WINDOW`:
- The post-increment accumulator values, including the closing sample, are the snapshot.
- All accumulators return to 0 on the same edge.

**Report register.**
- If `rpt_valid`=0, or `rpt_valid`=1 and `rpt_ready`=1 on that edge: the snapshot loads and `rpt_valid`=1.
- If `rpt_valid`=1 and `rpt_ready`=0: the snapshot is discarded, the held report is unchanged, and `rpt_overrun` is set.
- If `rpt_valid`=1, `rpt_ready`=1 and no snapshot is produced: `rpt_valid`=0 on the next edge.
- `rpt_*` fields stay stable while `rpt_valid`=1 and change only on a load.
- `rpt_ready` is ignored while `rpt_valid`=0.

**Clear and reset.**
- `clr` has priority over everything. On that edge it zeroes the pipeline, the accumulators and all `rpt_*` outputs, and clears `rpt_overrun`. A sample present at stage 1 or stage 2 during `clr` is lost.
- Reset (`rst_n`=0) does the same immediately, with no clock required. Every output reads 0 during reset.

## Timing
- Reset value of every output is 0; `rpt_overrun` is cleared only by reset or `clr`.
- Sample presented with `in_valid` before edge N: registered at N, counted at N+1.
- If that sample closes a window, `rpt_valid` is high after edge N+1.
- Throughput: one sample per cycle, with no backpressure on the input side.
- Report handshake: transfer occurs on a rising edge with `rpt_valid`=1 and `rpt_ready`=1.
- Minimum window spacing equals `WINDOW` cycles. With `WINDOW`=1, a report is produced every sampled cycle.
- Reset mid-window discards the partial window; counting restarts from 0 at the first valid sample after release.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-stream, with no clock edge between assertion and check. Expect all outputs 0 immediately; after release with no input, `rpt_valid` stays 0.
2. **Clean window.** `WINDOW`=4; 4 consecutive samples `in_a`=5, `in_b`=3, `gt`=1, `eq`=`lt`=0. Expect `rpt_valid`=1 two edges after the 4th sample, `rpt_samples`=4, all error counts 0.
3. **Mismatch counting.** `WINDOW`=4; one sample `in_a`=`in_b`=3 with all flags 0, one sample `in_a`=2, `in_b`=9 with `gt`=1, two correct samples. Expect `rpt_eq_err`=1, `rpt_gt_err`=1, `rpt_lt_err`=1, `rpt_any_err`=2.
4. **Overrun.** `WINDOW`=4, `rpt_ready`=0, 8 samples. Expect the first report held unchanged and `rpt_overrun`=1. Then `rpt_ready`=1 for one cycle: `rpt_valid`=0, `rpt_overrun` stays 1 until `clr`.
5. **Simultaneous accept and load.** `rpt_ready`=1 on the same edge a new snapshot closes. Expect `rpt_valid` to remain 1 with the new counts and `rpt_overrun`=0.
6. **Clear mid-window.** After 2 of 4 samples, pulse `clr`, then feed 4 samples. Expect exactly one report, with `rpt_samples`=4 covering only the post-clear samples.
